mips_mc_core: RTL

Multi-cycle, parametrised successor to the single-cycle MIPS top. One FSM sequences fetch/decode/execute/memory/writeback over handshaked instruction and data memory ports, so memories may stall. Adds halfword byte-enables, misalignment/illegal-opcode trap and a retire pulse. Sits at chip top in place of the single-cycle core.

---
 rtl/mips_mc_pkg.sv | 37 +++
 rtl/mips_mc_alu.sv | 30 +++
 rtl/mips_mc_core.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcode/funct encodings,
// FSM state and ALU operation enums, and the 16-bit sign-extension helper.
package mips_mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL
  } alu_op_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_mc_alu.sv
// Combinational ALU of the multi-cycle core. Arithmetic wraps at 32 bits,
// slt compares signed, shifts take their amount from the shamt field.
module mips_mc_alu
  import mips_mc_pkg::*;
(
  input  alu_op_t     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  shamt,
  output logic [31:0] result,
  output logic        zero
);

  // Select the operation result; zero flag drives beq/bne decisions.
  always_comb begin
    result = 32'd0;
    case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLL: result = b << shamt;
      ALU_SRL: result = b >> shamt;
      default: result = 32'd0;
    endcase
    zero = (result == 32'd0);
  end

endmodule

// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS core. One FSM walks IDLE/FETCH/DECODE/EXEC/MEM/WB and
// parks in TRAP on an illegal instruction or a misaligned data access.
// Handshake: a request (im_req/dm_req) stays high with address/data held
// stable until the matching ready is seen high in the same cycle; ready is
// ignored while its request is low.
// Optional macro MIPS_MC_PERF_CNT_EN adds cycle/instret counters; without it
// both counter ports read zero.
module mips_mc_core
  import mips_mc_pkg::*;
#(
  parameter int          ADDR_W   = 18,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              im_req,
  output logic [ADDR_W-3:0] im_addr,
  input  logic [31:0]       im_rdata,
  input  logic              im_ready,
  output logic              dm_req,
  output logic              dm_we,
  output logic [3:0]        dm_be,
  output logic [ADDR_W-3:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata,
  input  logic              dm_ready,
  output logic              retire,
  output logic              trap,
  output logic [31:0]       cycle_cnt,
  output logic [31:0]       instret_cnt
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [31:0]       ir_q, a_q, b_q, res_q;
  logic [31:0]       regs [32];
  logic [ADDR_W-3:0] dm_addr_q;
  logic [31:0]       dm_wdata_q;
  logic [3:0]        dm_be_q;
  logic              dm_we_q, half_sel_q;

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign funct  = ir_q[5:0];
  assign imm    = ir_q[15:0];

  logic    legal, is_alu_r, is_br, is_j, is_jal, is_jr;
  logic    is_load, is_store, is_half, use_imm;
  alu_op_t alu_op;

  // Instruction decode from IR; anything not recognised stays illegal.
  always_comb begin
    legal = 1'b0; is_alu_r = 1'b0; is_br = 1'b0; is_j = 1'b0; is_jal = 1'b0;
    is_jr = 1'b0; is_load = 1'b0; is_store = 1'b0; is_half = 1'b0;
    use_imm = 1'b0; alu_op = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        is_alu_r = 1'b1;
        legal    = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_JR:   begin is_jr = 1'b1; is_alu_r = 1'b0; end
          default: begin legal = 1'b0; is_alu_r = 1'b0; end
        endcase
      end
      OP_ADDI: begin legal = 1'b1; use_imm = 1'b1; end
      OP_LW:   begin legal = 1'b1; use_imm = 1'b1; is_load = 1'b1; end
      OP_LH:   begin legal = 1'b1; use_imm = 1'b1; is_load = 1'b1; is_half = 1'b1; end
      OP_SW:   begin legal = 1'b1; use_imm = 1'b1; is_store = 1'b1; end
      OP_SH:   begin legal = 1'b1; use_imm = 1'b1; is_store = 1'b1; is_half = 1'b1; end
      OP_BEQ, OP_BNE: begin legal = 1'b1; is_br = 1'b1; alu_op = ALU_SUB; end
      OP_J:    begin legal = 1'b1; is_j = 1'b1; end
      OP_JAL:  begin legal = 1'b1; is_j = 1'b1; is_jal = 1'b1; end
      default: legal = 1'b0;
    endcase
  end

  logic [31:0] alu_res;
  logic        alu_zero;

  mips_mc_alu u_alu (
    .op     (alu_op),
    .a      (a_q),
    .b      (use_imm ? sext16(imm) : b_q),
    .shamt  (ir_q[10:6]),
    .result (alu_res),
    .zero   (alu_zero)
  );

  logic [ADDR_W-1:0] pc4, br_tgt, j_tgt, pc_xfer, mem_addr;
  logic              ctrl_xfer, br_taken, misaligned;

  assign pc4      = pc_q + ADDR_W'(4);
  assign br_tgt   = pc4 + ADDR_W'(sext16(imm) << 2);
  assign br_taken = (opcode == OP_BEQ) ? alu_zero : !alu_zero;
  assign ctrl_xfer = is_br | is_j | is_jr;
  assign mem_addr = alu_res[ADDR_W-1:0];
  assign misaligned = is_half ? mem_addr[0] : (mem_addr[1:0] != 2'b00);

  // Jump targets keep the PC's upper bits only when the address is wider than 28 bits.
  if (ADDR_W > 28) begin : g_jhi
    assign j_tgt = {pc4[ADDR_W-1:28], ir_q[25:0], 2'b00};
  end else begin : g_jlo
    assign j_tgt = {ir_q[ADDR_W-3:0], 2'b00};
  end

  // Next PC for branch/jump/jr in EXEC.
  always_comb begin
    pc_xfer = pc4;
    if (is_jr)                pc_xfer = a_q[ADDR_W-1:0];
    else if (is_j)            pc_xfer = j_tgt;
    else if (is_br && br_taken) pc_xfer = br_tgt;
  end

  // Next-state and handshake/status outputs, all decoded from the state.
  always_comb begin
    state_d = state_q;
    im_req  = 1'b0;
    dm_req  = 1'b0;
    retire  = 1'b0;
    trap    = 1'b0;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH: begin
        im_req = 1'b1;
        if (im_ready) state_d = ST_DECODE;
      end
      ST_DECODE: state_d = legal ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        if (ctrl_xfer) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (is_load || is_store) begin
          state_d = misaligned ? ST_TRAP : ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dm_req = 1'b1;
        if (dm_ready) begin
          retire  = is_store;
          state_d = is_store ? ST_FETCH : ST_WB;
        end
      end
      ST_WB: begin
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_TRAP:   trap = 1'b1;
      default:   state_d = ST_TRAP;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  assign im_addr  = pc_q[ADDR_W-1:2];
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign dm_we    = dm_req & dm_we_q;
  assign dm_be    = dm_req ? dm_be_q : 4'b0000;

  // Datapath registers: IR, operands, result, PC and the held data request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= ADDR_W'(RESET_PC);
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      dm_be_q    <= '0;
      dm_we_q    <= 1'b0;
      half_sel_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: if (im_ready) ir_q <= im_rdata;
        ST_DECODE: begin
          a_q <= (rs == 5'd0) ? 32'd0 : regs[rs];
          b_q <= (rt == 5'd0) ? 32'd0 : regs[rt];
        end
        ST_EXEC: begin
          res_q <= alu_res;
          if (ctrl_xfer) pc_q <= pc_xfer;
          if ((is_load || is_store) && !misaligned) begin
            dm_addr_q  <= mem_addr[ADDR_W-1:2];
            dm_we_q    <= is_store;
            half_sel_q <= mem_addr[1];
            dm_wdata_q <= !is_store ? 32'd0 :
                          is_half ? {b_q[15:0], b_q[15:0]} : b_q;
            dm_be_q    <= !is_store ? 4'b0000 :
                          !is_half ? 4'b1111 :
                          mem_addr[1] ? 4'b1100 : 4'b0011;
          end
        end
        ST_MEM: if (dm_ready) begin
          if (is_store) pc_q <= pc4;
          else res_q <= !is_half ? dm_rdata :
                        sext16(half_sel_q ? dm_rdata[31:16] : dm_rdata[15:0]);
        end
        ST_WB: pc_q <= pc4;
        default: ;
      endcase
    end
  end

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  // Register-file write port: jal links in EXEC, everything else writes in WB.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = res_q;
    if (state_q == ST_EXEC && is_jal) begin
      rf_we    = 1'b1;
      rf_waddr = 5'd31;
      rf_wdata = 32'(pc4);
    end else if (state_q == ST_WB) begin
      rf_we    = 1'b1;
      rf_waddr = is_alu_r ? rd : rt;
    end
  end

  // Register file; $0 is never written so it always reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (rf_we && rf_waddr != 5'd0) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

`ifdef MIPS_MC_PERF_CNT_EN
  logic [31:0] cyc_q, ins_q;

  // Active-cycle and retired-instruction counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= 32'd0;
      ins_q <= 32'd0;
    end else begin
      if (state_q != ST_IDLE && state_q != ST_TRAP) cyc_q <= cyc_q + 32'd1;
      if (retire) ins_q <= ins_q + 32'd1;
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ins_q;
`else
  assign cycle_cnt   = 32'd0;
  assign instret_cnt = 32'd0;
`endif

endmodule
